// File: rtl/fetch_line_issue.sv
// Line-buffered instruction issue stage fed by the 32x72 instruction SRAM.
// Optional next-line prefetch is enabled by defining FETCH_PREFETCH_EN.
module fetch_line_issue #(
  parameter int               LINES   = 32,
  parameter int               SLOTS   = 8,
  parameter int               IW      = 9,
  parameter logic [IW-1:0]    HALT_OP = 9'h1FF,
  localparam int              AW      = $clog2(LINES),
  localparam int              SW      = $clog2(SLOTS),
  localparam int              PW      = AW + SW,
  localparam int              LW      = SLOTS * IW
) (
  input  logic          clka,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] start_addr,
  input  logic          redirect,
  input  logic [PW-1:0] redirect_addr,
  output logic          mem_ena,
  output logic [AW-1:0] mem_addra,
  input  logic [LW-1:0] mem_douta,
  output logic          ins_valid,
  input  logic          ins_ready,
  output logic [IW-1:0] ins_data,
  output logic [PW-1:0] ins_pc,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ISSUE
  } state_e;

  state_e          state_q;
  logic [PW-1:0]   pc_q;
  logic [LW-1:0]   line_q;
  logic [IW-1:0]   cur_ins;
  logic [AW-1:0]   cur_line;
  logic [AW-1:0]   nxt_line;
  logic            hs;
  logic            last_slot;
  logic            is_halt;

`ifdef FETCH_PREFETCH_EN
  logic [LW-1:0]   pf_q;
  logic            pf_valid_q;
`endif

  assign cur_ins   = line_q[pc_q[SW-1:0]*IW +: IW];
  assign cur_line  = pc_q[PW-1:SW];
  assign nxt_line  = cur_line + AW'(1);
  assign hs        = (state_q == ISSUE) & ins_ready;
  assign last_slot = &pc_q[SW-1:0];
  assign is_halt   = (cur_ins == HALT_OP);
  assign busy      = (state_q != IDLE);

  always_comb begin
    mem_ena   = 1'b0;
    mem_addra = '0;
    ins_valid = 1'b0;
    ins_data  = '0;
    ins_pc    = '0;
    unique case (state_q)
      LOAD: begin
        mem_ena   = 1'b1;
        mem_addra = cur_line;
      end
      ISSUE: begin
        ins_valid = 1'b1;
        ins_data  = cur_ins;
        ins_pc    = pc_q;
`ifdef FETCH_PREFETCH_EN
        if (!pf_valid_q) begin
          mem_ena   = 1'b1;
          mem_addra = nxt_line;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      line_q     <= '0;
`ifdef FETCH_PREFETCH_EN
      pf_q       <= '0;
      pf_valid_q <= 1'b0;
`endif
    end else if (redirect) begin
      pc_q       <= redirect_addr;
      state_q    <= LOAD;
`ifdef FETCH_PREFETCH_EN
      pf_valid_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            pc_q    <= start_addr;
            state_q <= LOAD;
          end
        end
        LOAD: begin
          line_q  <= mem_douta;
          state_q <= ISSUE;
        end
        ISSUE: begin
`ifdef FETCH_PREFETCH_EN
          if (!pf_valid_q && !(hs && last_slot)) begin
            pf_q       <= mem_douta;
            pf_valid_q <= 1'b1;
          end
`endif
          if (hs && is_halt) begin
            state_q    <= IDLE;
`ifdef FETCH_PREFETCH_EN
            pf_valid_q <= 1'b0;
`endif
          end else if (hs) begin
            pc_q <= pc_q + PW'(1);
            if (last_slot) begin
`ifdef FETCH_PREFETCH_EN
              // unbuffered prefetch: take this cycle's read directly
              line_q     <= pf_valid_q ? pf_q : mem_douta;
              pf_valid_q <= 1'b0;
`else
              state_q    <= LOAD;
`endif
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_line_issue.sv
// Directed bench for fetch_line_issue with a combinational SRAM model.
// Line L slot k holds L*8+k+1, except line 2 slot 2 which holds HALT_OP.
module tb_fetch_line_issue;

  logic        clka;
  logic        rst;
  logic        start;
  logic [7:0]  start_addr;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic        mem_ena;
  logic [4:0]  mem_addra;
  logic [71:0] mem_douta;
  logic        ins_valid;
  logic        ins_ready;
  logic [8:0]  ins_data;
  logic [7:0]  ins_pc;
  logic        busy;

  logic [71:0] mem [32];
  int npass;
  int ntot;

  fetch_line_issue dut (
    .clka          (clka),
    .rst           (rst),
    .start         (start),
    .start_addr    (start_addr),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .mem_ena       (mem_ena),
    .mem_addra     (mem_addra),
    .mem_douta     (mem_douta),
    .ins_valid     (ins_valid),
    .ins_ready     (ins_ready),
    .ins_data      (ins_data),
    .ins_pc        (ins_pc),
    .busy          (busy)
  );

  assign mem_douta = mem[mem_addra];

  initial clka = 1'b0;
  always #5 clka = ~clka;

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_ins(input string tag,
                         input logic [7:0] pc,
                         input logic [8:0] data);
    check({tag, "_valid"}, 32'(ins_valid), 32'd1);
    check({tag, "_pc"}, 32'(ins_pc), 32'(pc));
    check({tag, "_data"}, 32'(ins_data), 32'(data));
  endtask

  task automatic chk_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(ins_valid), 32'd0);
    check({tag, "_ena"}, 32'(mem_ena), 32'd0);
    check({tag, "_pc"}, 32'(ins_pc), 32'd0);
    check({tag, "_data"}, 32'(ins_data), 32'd0);
  endtask

  initial begin
    npass = 0;
    ntot  = 0;
    for (int l = 0; l < 32; l++)
      for (int k = 0; k < 8; k++)
        mem[l][k*9 +: 9] = 9'(l * 8 + k + 1);
    mem[2][2*9 +: 9] = 9'h1FF;

    rst = 1'b0;
    start = 1'b0;
    start_addr = 8'h00;
    redirect = 1'b0;
    redirect_addr = 8'h00;
    ins_ready = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    check("reset_addr", 32'(mem_addra), 32'd0);
    rst = 1'b1;
    tick();

    // sequential fetch across a line boundary
    ins_ready = 1'b1;
    start = 1'b1;
    start_addr = 8'h00;
    tick();
    start = 1'b0;
    check("seq_load_ena", 32'(mem_ena), 32'd1);
    check("seq_load_addr", 32'(mem_addra), 32'd0);
    check("seq_load_valid", 32'(ins_valid), 32'd0);
    check("seq_load_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk_ins("seq_l0", 8'(k), 9'(k + 1));
    end
    tick();
`ifndef FETCH_PREFETCH_EN
    check("seq_bubble_valid", 32'(ins_valid), 32'd0);
    check("seq_bubble_addr", 32'(mem_addra), 32'd1);
    tick();
`endif
    chk_ins("seq_l1a", 8'h08, 9'd9);
    tick();
    chk_ins("seq_l1b", 8'h09, 9'd10);

    // asynchronous reset mid-issue
    rst = 1'b0;
    #1;
    chk_idle("arst_now");
    rst = 1'b1;
    tick();
    tick();
    chk_idle("arst_after");

    // backpressure at pc 0x03
    start = 1'b1;
    start_addr = 8'h00;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk_ins("bp_pre", 8'h03, 9'd4);
    ins_ready = 1'b0;
    tick();
    chk_ins("bp_hold1", 8'h03, 9'd4);
    tick();
    chk_ins("bp_hold2", 8'h03, 9'd4);
    tick();
    chk_ins("bp_hold3", 8'h03, 9'd4);
    ins_ready = 1'b1;
    tick();
    chk_ins("bp_adv", 8'h04, 9'd5);

    // redirect mid-line with a pending instruction
    ins_ready = 1'b0;
    redirect = 1'b1;
    redirect_addr = 8'h2B;
    tick();
    redirect = 1'b0;
    check("rd_gap_valid", 32'(ins_valid), 32'd0);
    check("rd_gap_addr", 32'(mem_addra), 32'd5);
    tick();
    chk_ins("rd_target", 8'h2B, 9'd44);

    // redirect onto slot 7, then cross into line 1
    ins_ready = 1'b1;
    redirect = 1'b1;
    redirect_addr = 8'h07;
    tick();
    redirect = 1'b0;
    tick();
    chk_ins("rd7_first", 8'h07, 9'd8);
    tick();
`ifndef FETCH_PREFETCH_EN
    check("rd7_bubble", 32'(ins_valid), 32'd0);
    tick();
`endif
    chk_ins("rd7_next", 8'h08, 9'd9);

    // halt at 0x12 with an ignored start during issue
    redirect = 1'b1;
    redirect_addr = 8'h10;
    tick();
    redirect = 1'b0;
    tick();
    chk_ins("halt_a", 8'h10, 9'd17);
    start = 1'b1;
    start_addr = 8'h80;
    tick();
    start = 1'b0;
    chk_ins("halt_b", 8'h11, 9'd18);
    tick();
    chk_ins("halt_op", 8'h12, 9'h1FF);
    tick();
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_valid", 32'(ins_valid), 32'd0);
    check("halt_ena", 32'(mem_ena), 32'd0);

    // wrap from 0xFE; start in the cycle right after halt
    start = 1'b1;
    start_addr = 8'hFE;
    tick();
    start = 1'b0;
    check("wrap_load_addr", 32'(mem_addra), 32'd31);
    tick();
    chk_ins("wrap_fe", 8'hFE, 9'd255);
`ifdef FETCH_PREFETCH_EN
    check("wrap_pf_ena", 32'(mem_ena), 32'd1);
    check("wrap_pf_addr", 32'(mem_addra), 32'd0);
`endif
    tick();
    chk_ins("wrap_ff", 8'hFF, 9'd256);
    tick();
`ifndef FETCH_PREFETCH_EN
    check("wrap_load0_addr", 32'(mem_addra), 32'd0);
    check("wrap_load0_ena", 32'(mem_ena), 32'd1);
    tick();
`endif
    chk_ins("wrap_00", 8'h00, 9'd1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
